wb_arbiter: RTL and testbench

- Writeback arbiter and register scoreboard that drives the single write port of the 32x32 register file (write enable, destination index, write data).
- Merges two result sources:
  - ALU: fixed priority, no backpressure.
  - Load/store unit (LSU): valid/ready handshake, buffered in a small FIFO.
- Tracks which architectural registers have writes in flight so the decode stage can stall on read-after-write hazards.

---
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU/LSU result inputs, decode scoreboard
// queries and the register file write port.
interface wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic          stall;
  logic          wr_en;
  logic [AW-1:0] wr_rd;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] fifo_cnt;

  // Core side: drives results, issue and checks; observes the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  lsu_ready, stall, wr_en, wr_rd, wr_data, fifo_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
    output lsu_ready, stall, wr_en, wr_rd, wr_data, fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU has fixed priority, LSU results queue in a FIFO,
// and a pending-write scoreboard produces the decode stall.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2 ** AW;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [AW-1:0] cnt;
  logic [NR-1:0] pending;
  logic [NR-1:0] pending_nxt;

  logic          wr_en_q;
  logic [AW-1:0] wr_rd_q;
  logic [DW-1:0] wr_data_q;

  logic          fifo_empty;
  logic          ready;
  logic          push;
  logic          pop;
  logic          sel_valid;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic          write_ok;

  // Readiness uses only the registered count, so a full FIFO refuses a
  // push even when it pops in the same cycle.
  assign fifo_empty = (cnt == '0);
  assign ready      = (cnt != AW'(DEPTH));
  assign push       = bus.lsu_valid & ready;
  assign pop        = ~bus.alu_valid & ~fifo_empty;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = bus.alu_rd;
    sel_data  = bus.alu_data;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = rd_mem[head];
      sel_data  = data_mem[head];
    end
  end

  // A result targeting x0 is consumed but never reaches the register file.
  assign write_ok = sel_valid & (sel_rd != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= bus.lsu_rd;
      data_mem[tail] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= write_ok;
      if (write_ok) begin
        wr_rd_q   <= sel_rd;
        wr_data_q <= sel_data;
      end
    end
  end

  // Clear is applied before set so a same-cycle issue to the committing rd wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_en_q) pending_nxt[wr_rd_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) pending_nxt[bus.iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  assign bus.lsu_ready = ready;
  assign bus.fifo_cnt  = cnt;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_rd     = wr_rd_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.stall     = pending[bus.chk_rs1] | pending[bus.chk_rs2];
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; outputs are sampled 1 ns
// after each rising edge, inputs change at the same point.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  wb_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ldat;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [4:0] rd,
                            input logic [31:0] data);
    checkOutput({tag, "_wr_en"}, {31'd0, bus.wr_en}, {31'd0, en});
    if (en) begin
      checkOutput({tag, "_wr_rd"}, {27'd0, bus.wr_rd}, {27'd0, rd});
      checkOutput({tag, "_wr_data"}, bus.wr_data, data);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd0;
    bus.chk_rs1   = 5'd0;
    bus.chk_rs2   = 5'd0;

    // Reset and idle
    repeat (3) tick();
    checkOutput("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    checkOutput("rst_fifo_cnt", {27'd0, bus.fifo_cnt}, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rst_wr_rd", {27'd0, bus.wr_rd}, 32'd0);
    checkOutput("rst_wr_data", bus.wr_data, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_wr_en", {31'd0, bus.wr_en}, 32'd0);
    end

    // ALU path with scoreboard stall
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    tick();
    bus.iss_valid = 1'b0;
    bus.chk_rs1   = 5'd5;
    #1;
    checkOutput("alu_stall_pending", {31'd0, bus.stall}, 32'd1);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("alu_stall_commit_cycle", {31'd0, bus.stall}, 32'd1);
    tick();
    checkOutput("alu_after_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("alu_stall_cleared", {31'd0, bus.stall}, 32'd0);
    checkOutput("alu_hold_data", bus.wr_data, 32'hDEADBEEF);
    bus.chk_rs1 = 5'd0;

    // Collision: ALU first, LSU next cycle
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("coll_alu", 1'b1, 5'd3, 32'h11);
    checkOutput("coll_cnt1", {27'd0, bus.fifo_cnt}, 32'd1);
    tick();
    checkWrite("coll_lsu", 1'b1, 5'd7, 32'h22);
    checkOutput("coll_cnt0", {27'd0, bus.fifo_cnt}, 32'd0);
    tick();
    checkOutput("coll_idle", {31'd0, bus.wr_en}, 32'd0);

    // Backpressure: ALU holds priority for 6 cycles; four loads fill the FIFO
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 5'd1, 32'h100 + c, 1'b1, 5'd2, (c < 4) ? 32'hA0 + c : 32'hA4);
      checkOutput("bp_ready", {31'd0, bus.lsu_ready}, (c < 4) ? 32'd1 : 32'd0);
      tick();
      checkWrite("bp_alu", 1'b1, 5'd1, 32'h100 + c);
      checkOutput("bp_cnt", {27'd0, bus.fifo_cnt}, (c < 4) ? c + 1 : 32'd4);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hA4);
    checkOutput("bp_full_refuse", {31'd0, bus.lsu_ready}, 32'd0);
    tick();
    checkWrite("bp_pop0", 1'b1, 5'd2, 32'hA0);
    checkOutput("bp_cnt_pop0", {27'd0, bus.fifo_cnt}, 32'd3);
    checkOutput("bp_ready_again", {31'd0, bus.lsu_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("bp_pop1", 1'b1, 5'd2, 32'hA1);
    checkOutput("bp_cnt_pushpop", {27'd0, bus.fifo_cnt}, 32'd3);
    tick();
    checkWrite("bp_pop2", 1'b1, 5'd2, 32'hA2);
    checkOutput("bp_cnt_pop2", {27'd0, bus.fifo_cnt}, 32'd2);
    tick();
    checkWrite("bp_pop3", 1'b1, 5'd2, 32'hA3);
    tick();
    checkWrite("bp_pop4", 1'b1, 5'd2, 32'hA4);
    checkOutput("bp_cnt_empty", {27'd0, bus.fifo_cnt}, 32'd0);
    tick();
    checkOutput("bp_no_dup", {31'd0, bus.wr_en}, 32'd0);

    // x0 suppression on both sources
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h55);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("x0_alu_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("x0_cnt1", {27'd0, bus.fifo_cnt}, 32'd1);
    tick();
    checkOutput("x0_lsu_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("x0_cnt0", {27'd0, bus.fifo_cnt}, 32'd0);
    tick();
    checkOutput("x0_idle", {31'd0, bus.wr_en}, 32'd0);

    // Set/clear race on rd 9: the re-issue in the commit cycle wins
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("race_commit", 1'b1, 5'd9, 32'h99);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.chk_rs1   = 5'd9;
    #1;
    checkOutput("race_pending_rs1", {31'd0, bus.stall}, 32'd1);
    bus.chk_rs1 = 5'd0;
    bus.chk_rs2 = 5'd9;
    #1;
    checkOutput("race_pending_rs2", {31'd0, bus.stall}, 32'd1);
    bus.chk_rs2 = 5'd4;
    #1;
    checkOutput("race_other_idle", {31'd0, bus.stall}, 32'd0);
    bus.chk_rs1 = 5'd9;

    // Queue three loads behind the ALU, then pulse reset between edges
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 5'd4, 32'h40 + c, 1'b1, 5'd6 + c, 32'hB0 + c);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("mid_cnt3", {27'd0, bus.fifo_cnt}, 32'd3);
    checkWrite("mid_alu", 1'b1, 5'd4, 32'h42);
    checkOutput("mid_stall_before", {31'd0, bus.stall}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_cnt", {27'd0, bus.fifo_cnt}, 32'd0);
    checkOutput("async_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("async_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("async_ready", {31'd0, bus.lsu_ready}, 32'd1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      checkOutput("post_rst_cnt", {27'd0, bus.fifo_cnt}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
